tcb_mem_sub: RTL
================

Name: tcb_mem_sub

Overview:
- TCB subordinate endpoint: a word-organised memory with optional wait states and address/alignment error detection.
- Sits directly downstream of a TCB manager and terminates the bus.
- Honours the fixed response delay of 1 clock: read data and error are valid the cycle after the transfer.
- Used as the default RAM model and as the on-chip scratchpad behind TCB interconnect.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width; power of two, >= 8
BW, DW/8, byte enable width
DEPTH, 1024, number of DW-wide words in the array
WS, 0, wait states inserted before rdy per request (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
tcb_vld  input  1  request valid
tcb_wen  input  1  write enable (1 = write, 0 = read)
tcb_adr  input  AW  byte address
tcb_ben  input  BW  byte enables
tcb_wdt  input  DW  write data
tcb_rdt  output  DW  read data, valid the cycle after a read transfer
tcb_err  output  1  error, valid the cycle after any transfer
tcb_rdy  output  1  ready

Behaviour:
- Clock/reset: one clock (clk); rst asynchronous, active-low.
- Transfer: trn = tcb_vld & tcb_rdy.
- Manager must hold vld and all request fields stable until trn. If vld drops early, the wait counter clears and no access occurs.
- Word index: tcb_adr[AW-1:log2(BW)]. Byte offset: tcb_adr[log2(BW)-1:0].
- Error condition (evaluated at trn): word index >= DEPTH, OR byte offset != 0, OR ben == 0.
- Wait-state counter cnt (4 bits, reset 0):
  - tcb_rdy = (cnt == WS), combinational.
  - WS=0: rdy is constant 1 after reset.
  - vld & ~rdy: cnt <= cnt+1.
  - trn: cnt <= 0.
  - ~vld: cnt <= 0.
  - Back-to-back requests each see WS wait cycles.
- FSM (only when WS>0):
  - IDLE (cnt=0, no vld) -> WAIT on vld.
  - WAIT -> READY when cnt reaches WS.
  - READY -> IDLE on trn without vld next; READY -> WAIT if vld is held for a new request.
  - Encode as cnt plus the vld test; no extra state register.
- Write (trn & wen & ~error): for each byte i with ben[i]=1, mem[idx][8i+7:8i] <= wdt[8i+7:8i]. Other bytes unchanged.
- Write with error: memory untouched.
- Read (trn & ~wen & ~error): tcb_rdt <= mem[idx], the full word regardless of ben.
- Read with error: tcb_rdt <= 0.
- tcb_rdt holds its value until the next read transfer; it is not updated by writes.
- tcb_err: registered; on every trn <= error condition. Cycles without trn <= 0, so err is a one-cycle pulse aligned with the response slot.
- Read-after-write to the same word on consecutive transfers returns the new data (write at edge N, read sampled at edge N+1).
- Reset values:
  - tcb_rdt = 0, tcb_err = 0, cnt = 0.
  - tcb_rdy = 1 if WS=0, else 0.
  - Memory contents are not reset.
- Reset mid-operation: an outstanding wait is abandoned. A transfer in the cycle reset asserts is discarded (no write, no response).
- Address bits above the index range are checked via the DEPTH compare, so there is no aliasing.

Test Plan:
1. WS=0: write adr=0x10, ben=0xF, wdt=0xDEADBEEF; then read adr=0x10 -> rdy=1 both cycles; rdt=0xDEADBEEF and err=0 the cycle after the read.
2. Byte-enable merge: write 0x11223344 to adr 0x20, then write ben=0b0101 wdt=0xAABBCCDD, then read -> rdt=0x11BB33DD.
3. WS=3: vld held from cycle 0 -> rdy=0 in cycles 0-2, rdy=1 in cycle 3. A back-to-back second request repeats 3 wait cycles.
4. Errors:
   - read adr=DEPTH*4 (0x1000) -> err=1 one cycle, rdt=0.
   - write adr=0x02 -> err=1, memory at word 0 unchanged.
   - ben=0 -> err=1.
5. Response alignment: reads to 0x0, 0x4, 0x8 back-to-back with WS=0 -> rdt sequence matches the stored words, each one cycle after its trn; err stays 0; rdt holds the last value on following idle cycles.
6. Reset: assert rst=0 asynchronously mid-WAIT (WS=2) -> rdy, err, rdt go to reset values immediately. After release, a read returns pre-reset memory content.

Source files
------------

// File: rtl/tcb_mem_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tcb_mem_sub : TCB subordinate word memory with wait states and error |
// | Rev 1.0     : initial release                                        |
// +----------------------------------------------------------------------+
module tcb_mem_sub #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BW    = DW/8,
  parameter int DEPTH = 1024,
  parameter int WS    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tcb_vld,
  input  logic          tcb_wen,
  input  logic [AW-1:0] tcb_adr,
  input  logic [BW-1:0] tcb_ben,
  input  logic [DW-1:0] tcb_wdt,
  output logic [DW-1:0] tcb_rdt,
  output logic          tcb_err,
  output logic          tcb_rdy
);

  localparam int LB = (BW > 1) ? $clog2(BW) : 0;
  localparam int IW = AW - LB;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdt;
  logic          r_err;
  logic [3:0]    w_cnt;
  logic [IW-1:0] w_idx;
  logic [MW-1:0] w_addr;
  logic          w_off_err;
  logic          w_range_err;
  logic          w_err;
  logic          w_trn;

  // The wait-state FSM is just cnt: 0 without vld is IDLE, 0<cnt<WS is WAIT,
  // cnt==WS is READY; a held vld after trn restarts counting from 0.
  generate
    if (WS == 0) begin : g_nowait
      assign w_cnt = 4'd0;
    end else begin : g_wait
      logic [3:0] r_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= 4'd0;
        end else if (!tcb_vld || tcb_rdy) begin
          r_cnt <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      assign w_cnt = r_cnt;
    end
  endgenerate

  assign tcb_rdy = (w_cnt == 4'(WS));
  assign w_trn   = tcb_vld & tcb_rdy;

  generate
    if (LB > 0) begin : g_off
      assign w_off_err = |tcb_adr[LB-1:0];
    end else begin : g_nooff
      assign w_off_err = 1'b0;
    end
  endgenerate

  // Full-width compare catches every upper address bit, so nothing aliases.
  assign w_idx       = tcb_adr[AW-1:LB];
  assign w_addr      = w_idx[MW-1:0];
  assign w_range_err = ({1'b0, w_idx} >= (IW+1)'(DEPTH));
  assign w_err       = w_range_err | w_off_err | ~|tcb_ben;

  // rst gates the write so a transfer coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && w_trn && tcb_wen && !w_err) begin
      for (int i = 0; i < BW; i++) begin
        if (tcb_ben[i]) r_mem[w_addr][8*i +: 8] <= tcb_wdt[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_trn & w_err;
      if (w_trn && !tcb_wen) begin
        r_rdt <= w_err ? '0 : r_mem[w_addr];
      end
    end
  end

  assign tcb_rdt = r_rdt;
  assign tcb_err = r_err;

endmodule
`default_nettype wire
